sll_result_stage: RTL

- Registered output stage that sits directly downstream of the combinational sll element in the catalog.
- Captures the sll operands A and B, together with its result C, under a valid/ready handshake.
- Derives status flags (zero, bits-lost overflow) and holds results in a 2-entry skid buffer, so downstream back-pressure never drops or corrupts a result.
- Gives the combinational shifter a pipelined, flow-controlled interface for datapath use.

---
 rtl/sll_result_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sll_result_stage.sv
// sll_result_stage
// Registered, flow-controlled output stage for the combinational sll element.
// It captures an A/B/C triple under valid/ready and computes the status flags
// at capture. Results are held in a two-entry (main + skid) buffer, so
// back-pressure from downstream never drops or corrupts a result.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake (in_ready is registered)
//   in_a, in_b, in_c       operand A, shift amount B (unsigned), result C=A<<B
//   out_valid / out_ready  downstream handshake
//   out_c                  registered result
//   out_zero               out_c == 0
//   out_ovf                at least one 1-bit of A was shifted out
//   out_cnt                results delivered since reset (wraps)
//   chk_err                sticky recompute-mismatch flag; present only when
//                          the macro SLL_RESULT_CHECK_EN is defined
module sll_result_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
`ifdef SLL_RESULT_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] main_c_reg, skid_c_reg;
  logic             main_zero_reg, main_ovf_reg;
  logic             skid_zero_reg, skid_ovf_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic in_fire, out_fire;
  logic main_load_in, main_load_skid, skid_load;

  // Flags computed from the incoming triple.
  // The bits of A that survive the shift are those under ({WIDTH{1}} >> B).
  // Any 1 outside that mask is lost. This covers B==0 (empty lost set) and
  // B>=WIDTH (every bit lost) without special cases.
  logic [WIDTH-1:0] kept_mask;
  logic             cap_zero, cap_ovf;

  assign kept_mask = {WIDTH{1'b1}} >> in_b;
  assign cap_zero  = (in_c == '0);
  assign cap_ovf   = |(in_a & ~kept_mask);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Main takes the new triple when empty, or when it drains in the same cycle.
  // When main is held, the skid entry catches the new triple.
  assign main_load_in   = in_fire && ((state_reg == ST_EMPTY) ||
                                      (state_reg == ST_ONE && out_fire));
  assign skid_load      = in_fire && (state_reg == ST_ONE) && !out_fire;
  assign main_load_skid = (state_reg == ST_FULL) && out_fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_EMPTY;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (in_fire) state_next = ST_ONE;
      ST_ONE: begin
        if (in_fire && !out_fire)      state_next = ST_FULL;
        else if (!in_fire && out_fire) state_next = ST_EMPTY;
      end
      ST_FULL:  if (out_fire) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Outputs decoded from the registered state only. in_ready therefore never
  // depends combinationally on out_ready.
  always_comb begin
    out_valid = (state_reg != ST_EMPTY);
    in_ready  = (state_reg != ST_FULL);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_c_reg    <= '0;
      main_zero_reg <= 1'b0;
      main_ovf_reg  <= 1'b0;
      skid_c_reg    <= '0;
      skid_zero_reg <= 1'b0;
      skid_ovf_reg  <= 1'b0;
    end else begin
      if (main_load_in) begin
        main_c_reg    <= in_c;
        main_zero_reg <= cap_zero;
        main_ovf_reg  <= cap_ovf;
      end else if (main_load_skid) begin
        main_c_reg    <= skid_c_reg;
        main_zero_reg <= skid_zero_reg;
        main_ovf_reg  <= skid_ovf_reg;
      end
      if (skid_load) begin
        skid_c_reg    <= in_c;
        skid_zero_reg <= cap_zero;
        skid_ovf_reg  <= cap_ovf;
      end
    end
  end

  // Delivered-transaction counter
  always_ff @(posedge clk) begin
    if (rst)           cnt_reg <= '0;
    else if (out_fire) cnt_reg <= cnt_reg + CNT_W'(1);
  end

  assign out_c    = main_c_reg;
  assign out_zero = main_zero_reg;
  assign out_ovf  = main_ovf_reg;
  assign out_cnt  = cnt_reg;

`ifdef SLL_RESULT_CHECK_EN
  // Independent recompute of C. B is widened by one bit so that the
  // comparison against WIDTH sees the full shift amount.
  localparam logic [WIDTH:0] WIDTH_VAL = (WIDTH + 1)'(WIDTH);

  logic [WIDTH-1:0] recomputed_c;
  logic             chk_err_reg;

  assign recomputed_c = ({1'b0, in_b} >= WIDTH_VAL) ? '0 : (in_a << in_b);

  always_ff @(posedge clk) begin
    if (rst)                                   chk_err_reg <= 1'b0;
    else if (in_fire && (recomputed_c != in_c)) chk_err_reg <= 1'b1;
  end

  assign chk_err = chk_err_reg;
`endif

endmodule
